// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction memory.
// Accepts a byte stream over valid/ready and packs it into little-endian
// words. Each word is written with a one-cycle strobe. The CPU is held in
// reset until the last word of the image has been written.
module prog_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int DEPTH_WORDS   = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDRESS_WIDTH-1:0] len_i,
    input  logic                     byte_valid_i,
    input  logic [BYTE_WIDTH-1:0]    byte_data_i,
    output logic                     byte_ready_o,
    output logic                     we_o,
    output logic [ADDRESS_WIDTH-1:0] waddr_o,
    output logic [ADDRESS_WIDTH-1:0] wdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     cpu_rst_o,
    output logic                     error_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte capacity, one bit wider than the counter so 4*DEPTH_WORDS can
    // never alias to a small value.
    localparam logic [ADDRESS_WIDTH:0] CAPACITY = (ADDRESS_WIDTH+1)'(4 * DEPTH_WORDS);

    state_t                   state_reg;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] len_reg;
    logic [ADDRESS_WIDTH-1:0] count_reg;
    logic [ADDRESS_WIDTH-1:0] asm_reg;
    logic [ADDRESS_WIDTH-1:0] word_next;
    logic                     we_reg;
    logic [ADDRESS_WIDTH-1:0] waddr_reg;
    logic [ADDRESS_WIDTH-1:0] wdata_reg;
    logic                     error_reg;

    logic [1:0] lane;
    logic       start_ok;
    logic       accept;
    logic       is_final;
    logic       in_range;

    assign lane     = count_reg[1:0];
    assign start_ok = start_i && ((state_reg == IDLE) || (state_reg == DONE));
    assign accept   = byte_valid_i && (state_reg == LOAD);
    // Counter stops at len-1, so even a maximal length never wraps.
    assign is_final = (count_reg == (len_reg - 1'b1));
    assign in_range = ({1'b0, count_reg} < CAPACITY);

    // Insert the incoming byte into its lane; lane 0 starts a fresh word
    // so a short final word pads with zeros instead of stale bytes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_next[gi*BYTE_WIDTH +: BYTE_WIDTH] =
            (lane == 2'(gi)) ? byte_data_i :
            (lane == 2'd0)   ? '0 : asm_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_i) begin
                    state_next = (len_i == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept && is_final) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: counter, word assembly, registered write port and error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_reg   <= '0;
            count_reg <= '0;
            asm_reg   <= '0;
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            if (start_ok) begin
                len_reg   <= len_i;
                count_reg <= '0;
                asm_reg   <= '0;
                error_reg <= 1'b0;
            end else if (accept) begin
                count_reg <= count_reg + 1'b1;
                asm_reg   <= word_next;
                if (!in_range) begin
                    // Out-of-range bytes are drained but never written.
                    error_reg <= 1'b1;
                end else if ((lane == 2'd3) || is_final) begin
                    we_reg    <= 1'b1;
                    waddr_reg <= {count_reg[ADDRESS_WIDTH-1:2], 2'b00};
                    wdata_reg <= word_next;
                end
            end
        end
    end

    assign byte_ready_o = (state_reg == LOAD);
    assign busy_o       = (state_reg == LOAD) || (state_reg == FLUSH);
    assign done_o       = (state_reg == DONE);
    assign cpu_rst_o    = (state_reg != DONE);
    assign we_o         = we_reg;
    assign waddr_o      = waddr_reg;
    assign wdata_o      = wdata_reg;
    assign error_o      = error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected word writes,
// a negedge monitor pops and compares them whenever we_o is seen.
module tb_prog_loader;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic        busy_o;
    logic        done_o;
    logic        cpu_rst_o;
    logic        error_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic done_pending = 1'b0;

    prog_loader #(
        .ADDRESS_WIDTH(32),
        .BYTE_WIDTH(8),
        .DEPTH_WORDS(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .len_i(len_i),
        .byte_valid_i(byte_valid_i),
        .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o),
        .we_o(we_o),
        .waddr_o(waddr_o),
        .wdata_o(wdata_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .cpu_rst_o(cpu_rst_o),
        .error_o(error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic l);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every write strobe against the scoreboard, and the
    // cycle after a final write check that the CPU has been released.
    initial begin
        forever begin
            @(negedge clk_i);
            if (done_pending) begin
                done_pending = 1'b0;
                checks++;
                if (!(done_o === 1'b1 && cpu_rst_o === 1'b0 && busy_o === 1'b0)) begin
                    errors++;
                    $display("FAIL post_flush: done=%b cpu_rst=%b busy=%b expected 1 0 0",
                             done_o, cpu_rst_o, busy_o);
                end else begin
                    $display("ok   post_flush: done=1 cpu_rst=0 busy=0");
                end
            end
            if (we_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write: addr=0x%08h data=0x%08h expected no write",
                             waddr_o, wdata_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (waddr_o !== e.addr || wdata_o !== e.data) begin
                        errors++;
                        $display("FAIL write: got (0x%08h,0x%08h) expected (0x%08h,0x%08h)",
                                 waddr_o, wdata_o, e.addr, e.data);
                    end else begin
                        $display("ok   write: (0x%08h,0x%08h)", waddr_o, wdata_o);
                    end
                    if (e.last) begin
                        checks++;
                        if (!(busy_o === 1'b1 && done_o === 1'b0 && cpu_rst_o === 1'b1)) begin
                            errors++;
                            $display("FAIL flush_state: busy=%b done=%b cpu_rst=%b expected 1 0 1",
                                     busy_o, done_o, cpu_rst_o);
                        end else begin
                            $display("ok   flush_state: busy=1 done=0 cpu_rst=1");
                        end
                        done_pending = 1'b1;
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic do_start(input logic [31:0] l);
        start_i = 1'b1;
        len_i   = l;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (byte_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte 0x%02h not accepted within 20 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 20; k++) begin
            if (done_o === 1'b1) break;
            @(posedge clk_i);
            #1;
        end
        check(name, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        logic [7:0] basic [8];
        basic[0] = 8'h13; basic[1] = 8'h05; basic[2] = 8'hA0; basic[3] = 8'h00;
        basic[4] = 8'h93; basic[5] = 8'h05; basic[6] = 8'h10; basic[7] = 8'h00;

        rst_i = 1'b1;
        start_i = 1'b0;
        len_i = '0;
        byte_valid_i = 1'b0;
        byte_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_ready",   {31'd0, byte_ready_o}, 32'd0);
        check("reset_cpu_rst", {31'd0, cpu_rst_o},    32'd1);
        check("reset_done",    {31'd0, done_o},       32'd0);
        rst_i = 1'b0;
        idle(1);

        // Zero length: straight to DONE, no writes, never ready.
        do_start(32'd0);
        check("zero_done",    {31'd0, done_o},       32'd1);
        check("zero_cpu_rst", {31'd0, cpu_rst_o},    32'd0);
        check("zero_busy",    {31'd0, busy_o},       32'd0);
        idle(1);
        check("zero_ready",   {31'd0, byte_ready_o}, 32'd0);

        // Basic load, back-to-back bytes.
        expect_write(32'h0, 32'h00A00513, 1'b0);
        expect_write(32'h4, 32'h00100593, 1'b1);
        do_start(32'd8);
        check("start_done_drop", {31'd0, done_o},    32'd0);
        check("start_cpu_rst",   {31'd0, cpu_rst_o}, 32'd1);
        check("start_busy",      {31'd0, busy_o},    32'd1);
        for (int i = 0; i < 8; i++) send_byte(basic[i]);
        idle(1);
        wait_done("basic_done");
        idle(2);

        // Partial final word.
        expect_write(32'h0, 32'h04030201, 1'b0);
        expect_write(32'h4, 32'h00000605, 1'b1);
        do_start(32'd6);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
        idle(1);
        wait_done("partial_done");
        idle(2);

        // Throttled stream, valid toggling.
        expect_write(32'h0, 32'h44332211, 1'b1);
        do_start(32'd4);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h11 * (i + 1)));
            idle(2);
        end
        wait_done("throttle_done");
        idle(2);

        // Overflow: capacity is 8 bytes, image is 12.
        expect_write(32'h0, 32'h83828180, 1'b0);
        expect_write(32'h4, 32'h87868584, 1'b0);
        do_start(32'd12);
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(8'h80 + i));
            if (i == 7) check("ovf_error_before", {31'd0, error_o}, 32'd0);
            if (i == 8) check("ovf_error_set",    {31'd0, error_o}, 32'd1);
        end
        idle(1);
        wait_done("ovf_done");
        check("ovf_cpu_rst",    {31'd0, cpu_rst_o}, 32'd0);
        check("ovf_error_held", {31'd0, error_o},   32'd1);
        idle(2);

        // Reset mid-load after 5 of 8 bytes.
        expect_write(32'h0, 32'hC3C2C1C0, 1'b0);
        do_start(32'd8);
        check("start_clears_error", {31'd0, error_o}, 32'd0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("mid_rst_ready",   {31'd0, byte_ready_o}, 32'd0);
        check("mid_rst_we",      {31'd0, we_o},         32'd0);
        check("mid_rst_waddr",   waddr_o,               32'd0);
        check("mid_rst_wdata",   wdata_o,               32'd0);
        check("mid_rst_busy",    {31'd0, busy_o},       32'd0);
        check("mid_rst_done",    {31'd0, done_o},       32'd0);
        check("mid_rst_cpu_rst", {31'd0, cpu_rst_o},    32'd1);
        check("mid_rst_error",   {31'd0, error_o},      32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(1);

        // Restart: fresh word at address 0.
        expect_write(32'h0, 32'hDDCCBBAA, 1'b1);
        do_start(32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hAA + 8'h11 * i));
        idle(1);
        wait_done("restart_done");
        idle(2);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
